// File: rtl/instruction_fetch.sv
// instruction_fetch: prefetch stage between the instruction BRAM and controller.
// Streams sequential fetches into a small FIFO so the BRAM read latency is
// hidden, presents one instruction per cycle over valid/ready, flushes on
// redirect and flags end-of-program once everything has drained.
// Optional feature: define INSTR_FETCH_STATS_EN to add saturating
// handshake/redirect counters (fetch_count_out, flush_count_out).
module instruction_fetch #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int INSTRUCTION_COUNT = 8,
  parameter int BRAM_LATENCY      = 2,
  parameter int FIFO_DEPTH        = 4,
  localparam int ADDR_WIDTH       = $clog2(INSTRUCTION_COUNT)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  output logic [ADDR_WIDTH-1:0]        bram_addr_out,
  input  logic [INSTRUCTION_WIDTH-1:0] bram_data_in,
  output logic [INSTRUCTION_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]        instr_pc_out,
  output logic                         instr_valid_out,
  input  logic                         instr_ready_in,
  input  logic                         jump_valid_in,
  input  logic [ADDR_WIDTH:0]          jump_addr_in,
`ifdef INSTR_FETCH_STATS_EN
  output logic [31:0]                  fetch_count_out,
  output logic [31:0]                  flush_count_out,
`endif
  output logic                         program_done_out
);

  localparam int PC_W  = ADDR_WIDTH + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PC_W-1:0]  COUNT_L = PC_W'(INSTRUCTION_COUNT);
  localparam logic [CNT_W:0]   DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);

  // Fetch PC and the last address driven to the BRAM
  logic [PC_W-1:0]       pc;
  logic [ADDR_WIDTH-1:0] addr_q;

  // In-flight read tracking: one {valid, pc} slot per cycle of BRAM latency
  logic [BRAM_LATENCY-1:0] sr_vld;
  logic [ADDR_WIDTH-1:0]   sr_pc [BRAM_LATENCY];

  // Instruction FIFO; pointers wrap naturally since the depth is a power of two
  logic [INSTRUCTION_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]        fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             wr_ptr;
  logic [CNT_W-1:0]             count;

  logic [CNT_W-1:0] inflight;
  logic [CNT_W:0]   backlog;
  logic             pc_in_range;
  logic             fetch;
  logic             push;
  logic             pop;
  logic             done_cond;
  logic             done_q;

  // Count reads still travelling through the BRAM pipeline
  always_comb begin
    inflight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      inflight = inflight + CNT_W'(sr_vld[i]);
    end
  end

  // Issue only when the eventual results are guaranteed a FIFO slot, so a
  // stall can never overflow the buffer or drop a returning read.
  assign backlog     = {1'b0, count} + {1'b0, inflight};
  assign pc_in_range = (pc < COUNT_L);
  assign fetch       = !jump_valid_in && pc_in_range && (backlog < DEPTH_L);

  assign push = sr_vld[BRAM_LATENCY-1];
  assign pop  = instr_valid_out && instr_ready_in;

  assign bram_addr_out = fetch ? pc[ADDR_WIDTH-1:0] : addr_q;

  // Head is forced to zero when empty so stale entries never leak out
  assign instr_valid_out  = (count != '0);
  assign instr_out        = instr_valid_out ? fifo_instr[rd_ptr] : '0;
  assign instr_pc_out     = instr_valid_out ? fifo_pc[rd_ptr]    : '0;
  assign done_cond        = !pc_in_range && (count == '0) && (inflight == '0);
  assign program_done_out = done_q;

  // Control state: PC, issued-address hold, in-flight valids and FIFO pointers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc     <= '0;
      addr_q <= '0;
      sr_vld <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fetch) begin
        addr_q <= pc[ADDR_WIDTH-1:0];
      end
      if (jump_valid_in) begin
        pc <= jump_addr_in;
      end else if (fetch) begin
        pc <= pc + PC_W'(1);
      end
      if (jump_valid_in) begin
        // Redirect discards everything buffered or in flight; a coinciding
        // pop has already been accepted by the controller this cycle.
        sr_vld <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        for (int i = 1; i < BRAM_LATENCY; i++) begin
          sr_vld[i] <= sr_vld[i-1];
        end
        sr_vld[0] <= fetch;
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Datapath: in-flight PCs and FIFO storage, validity is tracked by control
  always_ff @(posedge clk_in) begin
    sr_pc[0] <= pc[ADDR_WIDTH-1:0];
    for (int i = 1; i < BRAM_LATENCY; i++) begin
      sr_pc[i] <= sr_pc[i-1];
    end
    if (push) begin
      fifo_instr[wr_ptr] <= bram_data_in;
      fifo_pc[wr_ptr]    <= sr_pc[BRAM_LATENCY-1];
    end
  end

  // Registered end-of-program flag; an in-range redirect clears it at once
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      done_q <= 1'b0;
    end else if (jump_valid_in) begin
      done_q <= done_q && (jump_addr_in >= COUNT_L);
    end else begin
      done_q <= done_cond;
    end
  end

`ifdef INSTR_FETCH_STATS_EN
  // Saturating counters of handshakes and redirects
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_count_out <= '0;
      flush_count_out <= '0;
    end else begin
      if (pop && (fetch_count_out != '1)) begin
        fetch_count_out <= fetch_count_out + 32'd1;
      end
      if (jump_valid_in && (flush_count_out != '1)) begin
        flush_count_out <= flush_count_out + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch with a BRAM
// model of fixed read latency. Expected PCs are queued as stimulus is set up
// and popped by a handshake monitor.
module tb_instruction_fetch;
  localparam int IW    = 32;
  localparam int IC    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(IC);

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic          jump;
  logic [AW:0]   jaddr;
  logic [AW-1:0] bram_addr;
  logic [IW-1:0] bram_data;
  logic [IW-1:0] instr;
  logic [AW-1:0] ipc;
  logic          ivalid;
  logic          done;
`ifdef INSTR_FETCH_STATS_EN
  logic [31:0]   fcnt;
  logic [31:0]   flcnt;
`endif

  logic [AW-1:0] addr_pipe [LAT];

  int exp_q[$];
  int n_cmp    = 0;
  int n_err    = 0;
  int hs_count = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .INSTRUCTION_WIDTH(IW),
    .INSTRUCTION_COUNT(IC),
    .BRAM_LATENCY(LAT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bram_addr_out(bram_addr),
    .bram_data_in(bram_data),
    .instr_out(instr),
    .instr_pc_out(ipc),
    .instr_valid_out(ivalid),
    .instr_ready_in(ready),
    .jump_valid_in(jump),
    .jump_addr_in(jaddr),
`ifdef INSTR_FETCH_STATS_EN
    .fetch_count_out(fcnt),
    .flush_count_out(flcnt),
`endif
    .program_done_out(done)
  );

  function automatic logic [IW-1:0] bram_word(input logic [AW-1:0] a);
    return {4'hA ^ {1'b0, a}, 20'h5A3C0, 5'd0, a};
  endfunction

  // BRAM model: data for the address presented LAT cycles earlier
  always @(posedge clk) begin
    addr_pipe[0] <= bram_addr;
    for (int i = 1; i < LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign bram_data = bram_word(addr_pipe[LAT-1]);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && ivalid && ready) begin
        hs_count++;
        check_eq("hs_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          int e;
          e = exp_q.pop_front();
          check_eq("hs_pc", 64'(ipc), 64'(e));
          check_eq("hs_instr", 64'(instr), 64'(bram_word(AW'(e))));
        end
      end
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst   = 1'b1;
    ready = rdy;
    jump  = 1'b0;
    jaddr = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    exp_q.delete();
    hs_count = 0;
    cyc = 0;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(i);
  endtask

  // Wait for the queue to drain, then check the registered done timing
  task automatic drain_and_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      next_cycle();
    end
    check_eq({tag, "_left"}, 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    check_eq({tag, "_done_lag"}, 64'(done), 64'(0));
    next_cycle();
    @(negedge clk);
    check_eq({tag, "_done"}, 64'(done), 64'(1));
    check_eq({tag, "_valid_end"}, 64'(ivalid), 64'(0));
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int max_addr;
    rst = 1'b1; ready = 1'b0; jump = 1'b0; jaddr = '0;
    fork
      monitor();
    join_none

    // Streaming from reset with ready held high
    do_reset(1'b1);
    push_range(0, IC-1);
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check_eq("rst_addr", 64'(bram_addr), 64'(0));
        check_eq("rst_instr", 64'(instr), 64'(0));
        check_eq("rst_pc", 64'(ipc), 64'(0));
`ifdef INSTR_FETCH_STATS_EN
        check_eq("rst_fcnt", 64'(fcnt), 64'(0));
        check_eq("rst_flcnt", 64'(flcnt), 64'(0));
`endif
      end
      check_eq("s1_valid", 64'(ivalid), 64'(c >= 3 && c <= 10));
      check_eq("s1_done", 64'(done), 64'(c >= 12));
      next_cycle();
    end
    check_eq("s1_left", 64'(exp_q.size()), 64'(0));

    // Stall: ready low for 10 cycles after the first valid
    do_reset(1'b0);
    push_range(0, IC-1);
    max_addr = 0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (int'(bram_addr) > max_addr) max_addr = int'(bram_addr);
      if (c >= 3) begin
        check_eq("s2_hold_valid", 64'(ivalid), 64'(1));
        check_eq("s2_hold_pc", 64'(ipc), 64'(0));
      end
      next_cycle();
    end
    check_eq("s2_max_fetch_addr", 64'(max_addr), 64'(3));
    ready = 1'b1;
    drain_and_done("s2", 40);

    // Jump to 2 together with the handshake of pc 5
    do_reset(1'b1);
    push_range(0, 5);
    push_range(2, IC-1);
    repeat (8) next_cycle();
    jump = 1'b1;
    jaddr = 4'd2;
    @(negedge clk);
    check_eq("s3_jump_head", 64'(ipc), 64'(5));
    next_cycle();
    jump = 1'b0;
    for (int c = 9; c <= 12; c++) begin
      @(negedge clk);
      if (c == 9) check_eq("s3_target_addr", 64'(bram_addr), 64'(2));
      check_eq("s3_valid", 64'(ivalid), 64'(c == 12));
      if (c == 12) check_eq("s3_first_pc", 64'(ipc), 64'(2));
      next_cycle();
    end
    drain_and_done("s3", 40);
    check_eq("s3_hs_count", 64'(hs_count), 64'(12));
`ifdef INSTR_FETCH_STATS_EN
    check_eq("s3_flush_count", 64'(flcnt), 64'(1));
    check_eq("s3_fetch_count", 64'(fcnt), 64'(hs_count));
`endif

    // Jump past the end of the program
    do_reset(1'b1);
    push_range(0, 2);
    repeat (5) next_cycle();
    jump = 1'b1;
    jaddr = 4'd8;
    @(negedge clk);
    check_eq("s4_jump_head", 64'(ipc), 64'(2));
    next_cycle();
    jump = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      @(negedge clk);
      check_eq("s4_valid", 64'(ivalid), 64'(0));
      check_eq("s4_done", 64'(done), 64'(c >= 7));
      next_cycle();
    end
    check_eq("s4_left", 64'(exp_q.size()), 64'(0));

    // Reset pulse with three instructions buffered
    do_reset(1'b0);
    repeat (5) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_eq("s5_pre_valid", 64'(ivalid), 64'(1));
    check_eq("s5_pre_pc", 64'(ipc), 64'(0));
    next_cycle();
    rst = 1'b0;
    ready = 1'b1;
    exp_q.delete();
    hs_count = 0;
    cyc = 0;
    push_range(0, IC-1);
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check_eq("s5_addr", 64'(bram_addr), 64'(0));
        check_eq("s5_instr", 64'(instr), 64'(0));
        check_eq("s5_pc", 64'(ipc), 64'(0));
        check_eq("s5_done", 64'(done), 64'(0));
`ifdef INSTR_FETCH_STATS_EN
        check_eq("s5_fcnt", 64'(fcnt), 64'(0));
`endif
      end
      check_eq("s5_valid", 64'(ivalid), 64'(c == 3));
      if (c == 3) check_eq("s5_first_pc", 64'(ipc), 64'(0));
      next_cycle();
    end
    drain_and_done("s5", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
